mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between instruction fetch and the load/store unit (LSU).

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/arb_starve_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and the muxed memory request payload for the fetch/LSU memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  localparam logic [3:0]  FETCH_BE = 4'hF;
  // Wide enough for the largest supported latency of 7.
  localparam int unsigned LAT_W    = 3;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of arbitrations lost by a pending fetch; sat tells the arbiter to let fetch win.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    sat   = (cnt_q == CNT_W'(STARVE_MAX));
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the LSU, one access at a time.
// Optional stall counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [3:0]        lsu_be,
  input  logic [31:0]       lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [31:0]       lsu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_lsu_stall
`endif
);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  logic             store_q, store_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      lsu_rdata_q, lsu_rdata_d;

  logic             rvalid_c;
  logic             arb_c;
  logic             if_win_c;
  logic             lsu_win_c;
  logic             starve_inc_c;
  logic             starve_sat;
  mem_req_t         req_c;
  logic             unused_addr_bits;

  // Arbitration happens in IDLE or in the response cycle; nothing is granted while reset is low.
  always_comb begin
    rvalid_c     = reset && (state_q == ARB_BUSY) && (lat_q == LAT_W'(MEM_LATENCY));
    arb_c        = reset && ((state_q == ARB_IDLE) || rvalid_c);
    if_win_c     = arb_c && if_req && (!lsu_req || starve_sat);
    lsu_win_c    = arb_c && lsu_req && !if_win_c;
    starve_inc_c = arb_c && if_req && lsu_win_c;
  end

  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc  (starve_inc_c),
    .clr  (if_win_c),
    .sat  (starve_sat)
  );

  always_comb begin
    req_c = '0;
    if (if_win_c) begin
      req_c.be   = FETCH_BE;
      req_c.addr = if_addr;
    end else if (lsu_win_c) begin
      req_c = '{we: lsu_we, be: lsu_be, addr: lsu_addr, wdata: lsu_wdata};
    end
  end

  assign unused_addr_bits = ^{req_c.addr[31:MEM_AW+2], req_c.addr[1:0]};

  always_comb begin
    mem_en     = if_win_c || lsu_win_c;
    mem_we     = req_c.we;
    mem_be     = req_c.be;
    mem_addr   = req_c.addr[MEM_AW+1:2];
    mem_wdata  = req_c.wdata;
    if_gnt     = if_win_c;
    lsu_gnt    = lsu_win_c;
    if_rvalid  = rvalid_c && (owner_q == OWN_IF);
    lsu_rvalid = rvalid_c && (owner_q == OWN_LSU);
    if_rdata   = if_rvalid ? mem_rdata : if_rdata_q;
    // Store acks return zero data.
    lsu_rdata  = lsu_rvalid ? (store_q ? 32'h0 : mem_rdata) : lsu_rdata_q;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    store_d     = store_q;
    lat_d       = lat_q;
    if_rdata_d  = if_rdata;
    lsu_rdata_d = lsu_rdata;
    case (state_q)
      ARB_IDLE: ;
      ARB_BUSY: begin
        if (rvalid_c) begin
          state_d = ARB_IDLE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (if_win_c || lsu_win_c) begin
      state_d = ARB_BUSY;
      lat_d   = LAT_W'(1);
      owner_d = lsu_win_c ? OWN_LSU : OWN_IF;
      store_d = lsu_win_c && lsu_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      store_q     <= 1'b0;
      lat_q       <= '0;
      if_rdata_q  <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      store_q     <= store_d;
      lat_q       <= lat_d;
      if_rdata_q  <= if_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall_q, perf_if_stall_d;
  logic [31:0] perf_lsu_stall_q, perf_lsu_stall_d;

  // Cycles a requester waits with its request up; wraps naturally at 2^32.
  always_comb begin
    perf_if_stall_d  = perf_if_stall_q + 32'(if_req && !if_win_c);
    perf_lsu_stall_d = perf_lsu_stall_q + 32'(lsu_req && !lsu_win_c);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_if_stall_q  <= '0;
      perf_lsu_stall_q <= '0;
    end else begin
      perf_if_stall_q  <= perf_if_stall_d;
      perf_lsu_stall_q <= perf_lsu_stall_d;
    end
  end

  assign perf_if_stall  = perf_if_stall_q;
  assign perf_lsu_stall = perf_lsu_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LATENCY=1 instance for cycle tables, a MEM_LATENCY=3 one for reset mid-access.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        lsu_req, lsu_we;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_addr, lsu_wdata, mem_rdata;

  logic        a_if_gnt, a_if_rvalid, a_lsu_gnt, a_lsu_rvalid, a_mem_en, a_mem_we;
  logic [31:0] a_if_rdata, a_lsu_rdata, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic [9:0]  a_mem_addr;
  logic        b_if_gnt, b_if_rvalid, b_lsu_gnt, b_lsu_rvalid, b_mem_en, b_mem_we;
  logic [31:0] b_if_rdata, b_lsu_rdata, b_mem_wdata;
  logic [3:0]  b_mem_be;
  logic [9:0]  b_mem_addr;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] a_perf_if, a_perf_lsu, b_perf_if, b_perf_lsu;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_AW(10), .MEM_LATENCY(1), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(a_lsu_gnt), .lsu_rvalid(a_lsu_rvalid), .lsu_rdata(a_lsu_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall(a_perf_if), .perf_lsu_stall(a_perf_lsu)
`endif
  );

  mem_port_arbiter #(.MEM_AW(10), .MEM_LATENCY(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(b_lsu_gnt), .lsu_rvalid(b_lsu_rvalid), .lsu_rdata(b_lsu_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall(b_perf_if), .perf_lsu_stall(b_perf_lsu)
`endif
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        lsu_req;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] mem_rdata;
    logic        e_if_gnt;
    logic        e_lsu_gnt;
    logic        e_if_rv;
    logic        e_lsu_rv;
    logic        e_en;
    logic        e_we;
    logic [3:0]  e_be;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_if_rdata;
    logic [31:0] e_lsu_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0; lsu_req = 1'b0; lsu_we = 1'b0;
    lsu_be = '0; lsu_addr = '0; lsu_wdata = '0; mem_rdata = '0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          if   if_addr        lsu   we    be     lsu_addr  wdata          mem_rdata      ifg   lsug  ifrv  lsurv en    we    be     addr     wdata          if_rdata       lsu_rdata
    vecs[0] = '{1'b1, 32'h8,        1'b0, 1'b0, 4'h0, '0,       '0,            '0,            1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 10'd2,   '0,            '0,            '0};
    vecs[1] = '{1'b0, '0,           1'b0, 1'b0, 4'h0, '0,       '0,            32'h11112222,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0,   '0,            32'h11112222,  '0};
    vecs[2] = '{1'b0, '0,           1'b1, 1'b1, 4'h3, 32'h10,   32'hDEADBEEF,  32'hAAAA5555,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 10'd4,   32'hDEADBEEF,  32'h11112222,  '0};
    vecs[3] = '{1'b0, '0,           1'b0, 1'b0, 4'h0, '0,       '0,            32'h5A5A5A5A,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 10'd0,   '0,            32'h11112222,  '0};
    vecs[4] = '{1'b1, 32'h20,       1'b1, 1'b0, 4'hF, 32'h40,   '0,            '0,            1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 10'h10,  '0,            32'h11112222,  '0};
    vecs[5] = '{1'b1, 32'h20,       1'b0, 1'b0, 4'h0, '0,       '0,            32'hCAFEF00D,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 10'd8,   '0,            32'h11112222,  32'hCAFEF00D};
    vecs[6] = '{1'b0, '0,           1'b0, 1'b0, 4'h0, '0,       '0,            32'h0BADC0DE,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0,   '0,            32'h0BADC0DE,  32'hCAFEF00D};
    vecs[7] = '{1'b0, '0,           1'b0, 1'b0, 4'h0, '0,       '0,            32'h12345678,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0,   '0,            32'h0BADC0DE,  32'hCAFEF00D};
    vecs[8] = '{1'b1, 32'hFFFFF00F, 1'b0, 1'b0, 4'h0, '0,       '0,            '0,            1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 10'h003, '0,            32'h0BADC0DE,  32'hCAFEF00D};
    vecs[9] = '{1'b0, '0,           1'b0, 1'b0, 4'h0, '0,       '0,            32'h00000077,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0,   '0,            32'h00000077,  32'hCAFEF00D};

    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state with idle inputs.
    @(negedge clk);
    chk("reset if_gnt", 32'(a_if_gnt), 32'h0);
    chk("reset lsu_gnt", 32'(a_lsu_gnt), 32'h0);
    chk("reset if_rvalid", 32'(a_if_rvalid), 32'h0);
    chk("reset lsu_rvalid", 32'(a_lsu_rvalid), 32'h0);
    chk("reset mem_en", 32'(a_mem_en), 32'h0);
    chk("reset mem_bus", {a_mem_we, a_mem_be, 17'h0, a_mem_addr} | a_mem_wdata, 32'h0);
    chk("reset if_rdata", a_if_rdata, 32'h0);
    chk("reset lsu_rdata", a_lsu_rdata, 32'h0);
    next_cycle();

    // Cycle table: single fetch, store, simultaneous requests, address slicing.
    for (int i = 0; i < 10; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      lsu_req = vecs[i].lsu_req; lsu_we = vecs[i].lsu_we; lsu_be = vecs[i].lsu_be;
      lsu_addr = vecs[i].lsu_addr; lsu_wdata = vecs[i].lsu_wdata; mem_rdata = vecs[i].mem_rdata;
      @(negedge clk);
      chk($sformatf("row%0d if_gnt", i), 32'(a_if_gnt), 32'(vecs[i].e_if_gnt));
      chk($sformatf("row%0d lsu_gnt", i), 32'(a_lsu_gnt), 32'(vecs[i].e_lsu_gnt));
      chk($sformatf("row%0d if_rvalid", i), 32'(a_if_rvalid), 32'(vecs[i].e_if_rv));
      chk($sformatf("row%0d lsu_rvalid", i), 32'(a_lsu_rvalid), 32'(vecs[i].e_lsu_rv));
      chk($sformatf("row%0d mem_en", i), 32'(a_mem_en), 32'(vecs[i].e_en));
      chk($sformatf("row%0d mem_we", i), 32'(a_mem_we), 32'(vecs[i].e_we));
      chk($sformatf("row%0d mem_be", i), 32'(a_mem_be), 32'(vecs[i].e_be));
      chk($sformatf("row%0d mem_addr", i), 32'(a_mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("row%0d mem_wdata", i), a_mem_wdata, vecs[i].e_wdata);
      chk($sformatf("row%0d if_rdata", i), a_if_rdata, vecs[i].e_if_rdata);
      chk($sformatf("row%0d lsu_rdata", i), a_lsu_rdata, vecs[i].e_lsu_rdata);
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    // Starvation: LSU held high wins four times, fetch forced through on the fifth arbitration.
    if_req = 1'b1; if_addr = 32'h100;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hF; lsu_addr = 32'h80; mem_rdata = 32'h0F0F0F0F;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("starve arb%0d lsu_gnt", k), 32'(a_lsu_gnt), (k < 4) ? 32'h1 : 32'h0);
      chk($sformatf("starve arb%0d if_gnt", k), 32'(a_if_gnt), (k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("starve arb%0d cnt", k), 32'(dut.u_starve.cnt_q), 32'(k));
      next_cycle();
    end
    if_req = 1'b0; lsu_req = 1'b0; mem_rdata = 32'h13579BDF;
    @(negedge clk);
    chk("starve if_rvalid", 32'(a_if_rvalid), 32'h1);
    chk("starve if_rdata", a_if_rdata, 32'h13579BDF);
    chk("starve cnt cleared", 32'(dut.u_starve.cnt_q), 32'h0);
    next_cycle();
    next_cycle();

    // MEM_LATENCY=3: reset one cycle after a grant drops the access.
    pulse_reset();
    if_req = 1'b1; if_addr = 32'hC;
    @(negedge clk);
    chk("lat3 if_gnt", 32'(b_if_gnt), 32'h1);
    chk("lat3 mem_addr", 32'(b_mem_addr), 32'h3);
    next_cycle();
    if_req = 1'b0; reset = 1'b0; mem_rdata = 32'hFEEDFACE;
    @(negedge clk);
    chk("lat3 in-reset mem_en", 32'(b_mem_en), 32'h0);
    chk("lat3 in-reset if_rvalid", 32'(b_if_rvalid), 32'h0);
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("lat3 post-reset%0d if_rvalid", k), 32'(b_if_rvalid), 32'h0);
      chk($sformatf("lat3 post-reset%0d lsu_rvalid", k), 32'(b_lsu_rvalid), 32'h0);
      chk($sformatf("lat3 post-reset%0d if_rdata", k), b_if_rdata, 32'h0);
      chk($sformatf("lat3 post-reset%0d mem_en", k), 32'(b_mem_en), 32'h0);
      next_cycle();
    end
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hF; lsu_addr = 32'h44;
    @(negedge clk);
    chk("lat3 lsu_gnt", 32'(b_lsu_gnt), 32'h1);
    chk("lat3 lsu mem_addr", 32'(b_mem_addr), 32'h11);
    next_cycle();
    lsu_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) mem_rdata = 32'h600DF00D;
      @(negedge clk);
      chk($sformatf("lat3 wait%0d lsu_rvalid", k), 32'(b_lsu_rvalid), (k == 3) ? 32'h1 : 32'h0);
      if (k == 3) chk("lat3 lsu_rdata", b_lsu_rdata, 32'h600DF00D);
      next_cycle();
    end

`ifdef ARB_PERF_CNT_EN
    // Replay of simultaneous requests on the latency-1 instance.
    pulse_reset();
    if_req = 1'b1; if_addr = 32'h20; lsu_req = 1'b1; lsu_be = 4'hF; lsu_addr = 32'h40;
    next_cycle();
    lsu_req = 1'b0;
    next_cycle();
    if_req = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("perf_if_stall", a_perf_if, 32'h1);
    chk("perf_lsu_stall", a_perf_lsu, 32'h0);
    next_cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
